// File: rtl/retire_queue.sv
// retire_queue: in-order retire buffer that sits downstream of the reservation station.
// Each dispatched instruction gets one entry, and the entry's index is its ROB number.
// Functional units mark entries done through two completion ports.
// When the oldest entry is done it retires: its result goes out to the architectural
// register file, and its superseded physical register goes back to the free pool.
// Optional feature: define RETIRE_QUEUE_FLUSH_EN to add a 'flush' input.
// Flush empties the queue in one edge.
module retire_queue #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int PREG_W = 6,
   parameter int AREG_W = 5,
   parameter int DATA_W = 32,
   parameter int PC_W   = 12
) (
   input  logic              clk,
   input  logic              rst,
`ifdef RETIRE_QUEUE_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              disp_valid,
   output logic              disp_ready,
   input  logic [PC_W-1:0]   disp_pc,
   input  logic              disp_reg_write,
   input  logic [AREG_W-1:0] disp_rd_arch,
   input  logic [PREG_W-1:0] disp_rd_phys,
   input  logic [PREG_W-1:0] disp_rd_old,
   output logic [IDX_W-1:0]  disp_rob_num,
   input  logic              cmpl0_valid,
   input  logic [IDX_W-1:0]  cmpl0_rob_num,
   input  logic [DATA_W-1:0] cmpl0_data,
   input  logic              cmpl1_valid,
   input  logic [IDX_W-1:0]  cmpl1_rob_num,
   input  logic [DATA_W-1:0] cmpl1_data,
   output logic              ret_valid,
   output logic [PC_W-1:0]   ret_pc,
   output logic              ret_reg_write,
   output logic [AREG_W-1:0] ret_rd_arch,
   output logic [PREG_W-1:0] ret_rd_phys,
   output logic [DATA_W-1:0] ret_data,
   output logic              free_push,
   output logic [PREG_W-1:0] free_reg,
   output logic [IDX_W:0]    count
);

   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

   // Dispatch handshake: a transfer happens on a rising edge where disp_valid and
   // disp_ready are both high. disp_ready depends only on the registered count, so a
   // retire in the same cycle does not open a slot until the following cycle.
   // disp_rob_num is valid whenever disp_ready is high.

   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_done;
   logic [PC_W-1:0]   r_pc   [DEPTH];
   logic              r_rw   [DEPTH];
   logic [AREG_W-1:0] r_arch [DEPTH];
   logic [PREG_W-1:0] r_phys [DEPTH];
   logic [PREG_W-1:0] r_old  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [IDX_W-1:0]  r_head;
   logic [IDX_W-1:0]  r_tail;
   logic [IDX_W:0]    r_count;

   logic w_flush;
   logic w_disp;
   logic w_ret;
   logic w_c0;
   logic w_c1;

`ifdef RETIRE_QUEUE_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign disp_ready   = (r_count < FULL_CNT);
   assign disp_rob_num = r_tail;
   assign count        = r_count;

   assign w_disp = disp_valid & disp_ready;
   // Retire is decided from registered state only.
   // A completion therefore never bypasses into the same edge's retire.
   assign w_ret  = r_valid[r_head] & r_done[r_head];
   // Completions only count against entries that are already valid.
   assign w_c0   = cmpl0_valid & r_valid[cmpl0_rob_num];
   assign w_c1   = cmpl1_valid & r_valid[cmpl1_rob_num];

   // Queue control: pointers, occupancy and per-entry valid/done flags.
   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_valid <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_ret) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         // The tail slot is never valid when dispatch is allowed.
         // So this cannot collide with a completion or a retire of the same slot.
         if (w_disp) begin
            r_valid[r_tail] <= 1'b1;
            r_done[r_tail]  <= 1'b0;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_c1) r_done[cmpl1_rob_num] <= 1'b1;
         if (w_c0) r_done[cmpl0_rob_num] <= 1'b1;
         case ({w_disp, w_ret})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry payload captured at dispatch. No reset is needed because the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (w_disp) begin
         r_pc[r_tail]   <= disp_pc;
         r_rw[r_tail]   <= disp_reg_write;
         r_arch[r_tail] <= disp_rd_arch;
         r_phys[r_tail] <= disp_rd_phys;
         r_old[r_tail]  <= disp_rd_old;
      end
   end

   // Result capture. Port 0 is written last, so it wins when both ports target one entry.
   always_ff @(posedge clk) begin
      if (w_c1) r_data[cmpl1_rob_num] <= cmpl1_data;
      if (w_c0) r_data[cmpl0_rob_num] <= cmpl0_data;
   end

   // Registered retire and free-pool outputs. They pulse for one cycle and otherwise hold their fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         ret_valid     <= 1'b0;
         ret_pc        <= '0;
         ret_reg_write <= 1'b0;
         ret_rd_arch   <= '0;
         ret_rd_phys   <= '0;
         ret_data      <= '0;
         free_push     <= 1'b0;
         free_reg      <= '0;
      end else if (w_flush) begin
         ret_valid <= 1'b0;
         free_push <= 1'b0;
      end else begin
         ret_valid <= w_ret;
         free_push <= w_ret & r_rw[r_head] & (r_arch[r_head] != '0);
         if (w_ret) begin
            ret_pc        <= r_pc[r_head];
            ret_reg_write <= r_rw[r_head];
            ret_rd_arch   <= r_arch[r_head];
            ret_rd_phys   <= r_phys[r_head];
            ret_data      <= r_data[r_head];
            free_reg      <= r_old[r_head];
         end
      end
   end

endmodule

// File: tb/tb_retire_queue.sv
// tb_retire_queue: randomized and directed stimulus for retire_queue.
// A behavioural model keeps the ROB as an ordered queue of in-flight instructions.
// Retirements predicted by the model are pushed into exp_q.
// An independent monitor pops exp_q when the DUT pulses ret_valid.
module tb_retire_queue;

   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;
   localparam int PREG_W = 6;
   localparam int AREG_W = 5;
   localparam int DATA_W = 32;
   localparam int PC_W   = 12;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              disp_valid = 1'b0;
   logic              disp_ready;
   logic [PC_W-1:0]   disp_pc = '0;
   logic              disp_reg_write = 1'b0;
   logic [AREG_W-1:0] disp_rd_arch = '0;
   logic [PREG_W-1:0] disp_rd_phys = '0;
   logic [PREG_W-1:0] disp_rd_old = '0;
   logic [IDX_W-1:0]  disp_rob_num;
   logic              cmpl0_valid = 1'b0;
   logic [IDX_W-1:0]  cmpl0_rob_num = '0;
   logic [DATA_W-1:0] cmpl0_data = '0;
   logic              cmpl1_valid = 1'b0;
   logic [IDX_W-1:0]  cmpl1_rob_num = '0;
   logic [DATA_W-1:0] cmpl1_data = '0;
   logic              ret_valid;
   logic [PC_W-1:0]   ret_pc;
   logic              ret_reg_write;
   logic [AREG_W-1:0] ret_rd_arch;
   logic [PREG_W-1:0] ret_rd_phys;
   logic [DATA_W-1:0] ret_data;
   logic              free_push;
   logic [PREG_W-1:0] free_reg;
   logic [IDX_W:0]    count;

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   retire_queue dut (
      .clk(clk), .rst(rst),
`ifdef RETIRE_QUEUE_FLUSH_EN
      .flush(flush),
`endif
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
      .disp_reg_write(disp_reg_write), .disp_rd_arch(disp_rd_arch),
      .disp_rd_phys(disp_rd_phys), .disp_rd_old(disp_rd_old), .disp_rob_num(disp_rob_num),
      .cmpl0_valid(cmpl0_valid), .cmpl0_rob_num(cmpl0_rob_num), .cmpl0_data(cmpl0_data),
      .cmpl1_valid(cmpl1_valid), .cmpl1_rob_num(cmpl1_rob_num), .cmpl1_data(cmpl1_data),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_reg_write(ret_reg_write),
      .ret_rd_arch(ret_rd_arch), .ret_rd_phys(ret_rd_phys), .ret_data(ret_data),
      .free_push(free_push), .free_reg(free_reg), .count(count)
   );

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic [IDX_W-1:0]  rob;
      logic [PC_W-1:0]   pc;
      logic              rw;
      logic [AREG_W-1:0] arch;
      logic [PREG_W-1:0] phys;
      logic [PREG_W-1:0] old;
      logic              done;
      logic [DATA_W-1:0] data;
   } ent_t;

   typedef struct {
      int                cyc;
      logic [PC_W-1:0]   pc;
      logic              rw;
      logic [AREG_W-1:0] arch;
      logic [PREG_W-1:0] phys;
      logic [DATA_W-1:0] data;
      logic              fp;
      logic [PREG_W-1:0] fr;
   } ret_t;

   ent_t mq[$];      // in-flight instructions, oldest first
   int   m_tail = 0; // next ROB number handed out
   ret_t exp_q[$];   // expected retirements, tagged with the edge that produces them

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Staged inputs for the next edge.
   logic              s_rst, s_flush, s_dv, s_rw, s_c0v, s_c1v;
   logic [PC_W-1:0]   s_pc;
   logic [AREG_W-1:0] s_ra;
   logic [PREG_W-1:0] s_rp, s_ro;
   logic [IDX_W-1:0]  s_c0n, s_c1n;
   logic [DATA_W-1:0] s_c0d, s_c1d;

   task automatic clear_stage();
      s_rst = 1'b0; s_flush = 1'b0; s_dv = 1'b0; s_rw = 1'b0; s_c0v = 1'b0; s_c1v = 1'b0;
      s_pc = '0; s_ra = '0; s_rp = '0; s_ro = '0;
      s_c0n = '0; s_c1n = '0; s_c0d = '0; s_c1d = '0;
   endtask

   task automatic disp(input logic [PC_W-1:0] pc, input logic rw, input logic [AREG_W-1:0] ra,
                       input logic [PREG_W-1:0] rp, input logic [PREG_W-1:0] ro);
      s_dv = 1'b1; s_pc = pc; s_rw = rw; s_ra = ra; s_rp = rp; s_ro = ro;
   endtask

   task automatic cmpl0(input logic [IDX_W-1:0] n, input logic [DATA_W-1:0] d);
      s_c0v = 1'b1; s_c0n = n; s_c0d = d;
   endtask

   task automatic cmpl1(input logic [IDX_W-1:0] n, input logic [DATA_W-1:0] d);
      s_c1v = 1'b1; s_c1n = n; s_c1d = d;
   endtask

   // One cycle runs in this order.
   // 1. Compare the visible state with the model.
   // 2. Apply the staged inputs.
   // 3. Advance the model across the coming edge.
   task automatic step();
      ret_t r;
      ent_t e;
      bit   do_ret, do_disp;
      @(negedge clk);
      chk("count", 64'(count), 64'(mq.size()));
      chk("disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH));
      chk("disp_rob_num", 64'(disp_rob_num), 64'(m_tail));
      rst = s_rst; flush = s_flush;
      disp_valid = s_dv; disp_pc = s_pc; disp_reg_write = s_rw;
      disp_rd_arch = s_ra; disp_rd_phys = s_rp; disp_rd_old = s_ro;
      cmpl0_valid = s_c0v; cmpl0_rob_num = s_c0n; cmpl0_data = s_c0d;
      cmpl1_valid = s_c1v; cmpl1_rob_num = s_c1n; cmpl1_data = s_c1d;
      if (s_rst || s_flush) begin
         mq.delete();
         m_tail = 0;
      end else begin
         do_ret  = (mq.size() > 0) && mq[0].done;
         do_disp = s_dv && (mq.size() < DEPTH);
         if (do_ret) begin
            r.cyc  = edge_cnt + 1;
            r.pc   = mq[0].pc;
            r.rw   = mq[0].rw;
            r.arch = mq[0].arch;
            r.phys = mq[0].phys;
            r.data = mq[0].data;
            r.fp   = mq[0].rw && (mq[0].arch != 0);
            r.fr   = mq[0].old;
            exp_q.push_back(r);
         end
         foreach (mq[i]) begin
            if (s_c1v && mq[i].rob == s_c1n) begin mq[i].done = 1'b1; mq[i].data = s_c1d; end
            if (s_c0v && mq[i].rob == s_c0n) begin mq[i].done = 1'b1; mq[i].data = s_c0d; end
         end
         if (do_ret) void'(mq.pop_front());
         if (do_disp) begin
            e.rob  = IDX_W'(m_tail);
            e.pc   = s_pc;
            e.rw   = s_rw;
            e.arch = s_ra;
            e.phys = s_rp;
            e.old  = s_ro;
            e.done = 1'b0;
            e.data = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
      clear_stage();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_reset_outs();
      chk("rst_ret_valid", 64'(ret_valid), 64'(0));
      chk("rst_ret_pc", 64'(ret_pc), 64'(0));
      chk("rst_ret_reg_write", 64'(ret_reg_write), 64'(0));
      chk("rst_ret_rd_arch", 64'(ret_rd_arch), 64'(0));
      chk("rst_ret_rd_phys", 64'(ret_rd_phys), 64'(0));
      chk("rst_ret_data", 64'(ret_data), 64'(0));
      chk("rst_free_push", 64'(free_push), 64'(0));
      chk("rst_free_reg", 64'(free_reg), 64'(0));
   endtask

   // ---------------- monitor ----------------
   initial begin
      ret_t r;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
            r = exp_q.pop_front();
            chk("ret_valid", 64'(ret_valid), 64'(1));
            chk("ret_pc", 64'(ret_pc), 64'(r.pc));
            chk("ret_reg_write", 64'(ret_reg_write), 64'(r.rw));
            chk("ret_rd_arch", 64'(ret_rd_arch), 64'(r.arch));
            chk("ret_rd_phys", 64'(ret_rd_phys), 64'(r.phys));
            chk("ret_data", 64'(ret_data), 64'(r.data));
            chk("free_push", 64'(free_push), 64'(r.fp));
            if (r.fp) chk("free_reg", 64'(free_reg), 64'(r.fr));
         end else begin
            chk("ret_valid_idle", 64'(ret_valid), 64'(0));
            chk("free_push_idle", 64'(free_push), 64'(0));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int stale;
      clear_stage();
      s_rst = 1'b1; step();
      s_rst = 1'b1; step();
      chk_reset_outs();

      // Basic dispatch, completion and retire.
      disp(12'h004, 1'b1, 5'd3, 6'd40, 6'd3); step();
      cmpl0(4'd0, 32'h55); step();
      idle(4);

      // Out-of-order completion, in-order retire.
      s_rst = 1'b1; step();
      disp(12'h010, 1'b1, 5'd1, 6'd10, 6'd1); step();
      disp(12'h014, 1'b1, 5'd2, 6'd11, 6'd2); step();
      disp(12'h018, 1'b1, 5'd4, 6'd12, 6'd4); step();
      cmpl0(4'd2, 32'h222); step();
      idle(2);
      cmpl1(4'd1, 32'h111); step();
      idle(2);
      cmpl0(4'd0, 32'h100); step();
      idle(5);

      // Fill to capacity, attempt an extra dispatch, then drain one entry and wrap.
      s_rst = 1'b1; step();
      for (int i = 0; i < DEPTH; i++) begin
         disp(PC_W'(12'h100 + 4 * i), 1'b1, AREG_W'(i + 1), PREG_W'(32 + i), PREG_W'(i)); step();
      end
      disp(12'hFFF, 1'b1, 5'd7, 6'd63, 6'd9); step();
      chk("full_count", 64'(count), 64'(DEPTH));
      chk("full_ready", 64'(disp_ready), 64'(0));
      cmpl0(4'd0, 32'hCAFE); step();
      idle(3);
      chk("wrap_rob_num", 64'(disp_rob_num), 64'(0));
      disp(12'h200, 1'b0, 5'd0, 6'd0, 6'd0); step();
      idle(2);

      // Same-cycle dispatch and retire at count 5; dual completion to one entry.
      s_rst = 1'b1; step();
      for (int i = 0; i < 5; i++) begin
         disp(PC_W'(12'h300 + 4 * i), 1'b1, AREG_W'(i + 8), PREG_W'(20 + i), PREG_W'(8 + i)); step();
      end
      cmpl0(4'd0, 32'h1); step();
      disp(12'h320, 1'b1, 5'd13, 6'd25, 6'd13); step();
      chk("same_cycle_count", 64'(count), 64'(5));
      cmpl0(4'd4, 32'hA); cmpl1(4'd4, 32'hB); step();
      cmpl0(4'd1, 32'h2); cmpl1(4'd2, 32'h3); step();
      cmpl0(4'd3, 32'h4); cmpl1(4'd5, 32'h6); step();
      idle(8);

      // rd_arch 0 and no-write entries never release a register.
      disp(12'h400, 1'b1, 5'd0, 6'd50, 6'd5); step();
      disp(12'h404, 1'b0, 5'd6, 6'd51, 6'd6); step();
      cmpl0(4'd6, 32'h77); cmpl1(4'd7, 32'h88); step();
      idle(4);

      // Reset with completed work still queued.
      disp(12'h500, 1'b1, 5'd1, 6'd1, 6'd2); step();
      disp(12'h504, 1'b1, 5'd2, 6'd3, 6'd4); step();
      disp(12'h508, 1'b1, 5'd3, 6'd5, 6'd6); step();
      cmpl0(4'd9, 32'h9); cmpl1(4'd10, 32'hA0); step();
      s_rst = 1'b1; cmpl0(4'd8, 32'h8); step();
      step();
      chk_reset_outs();
      idle(3);

`ifdef RETIRE_QUEUE_FLUSH_EN
      // Flush wins over a concurrent dispatch.
      disp(12'h600, 1'b1, 5'd4, 6'd44, 6'd4); step();
      cmpl0(4'd0, 32'h60); step();
      s_flush = 1'b1; disp(12'h604, 1'b1, 5'd5, 6'd45, 6'd5); step();
      chk("flush_count", 64'(count), 64'(0));
      idle(3);
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         s_rst = ($urandom_range(0, 399) == 0);
`ifdef RETIRE_QUEUE_FLUSH_EN
         s_flush = ($urandom_range(0, 249) == 0);
`endif
         if ($urandom_range(0, 99) < 60)
            disp(PC_W'($urandom), 1'($urandom), AREG_W'($urandom_range(0, 31)),
                 PREG_W'($urandom), PREG_W'($urandom));
         if ($urandom_range(0, 99) < 45) begin
            if (mq.size() > 0 && $urandom_range(0, 9) != 0)
               cmpl0(mq[$urandom_range(0, mq.size() - 1)].rob, $urandom);
            else
               cmpl0(IDX_W'($urandom), $urandom);
         end
         if ($urandom_range(0, 99) < 40) begin
            if (mq.size() > 0 && $urandom_range(0, 9) != 0)
               cmpl1(mq[$urandom_range(0, mq.size() - 1)].rob, $urandom);
            else
               cmpl1(IDX_W'($urandom), $urandom);
         end
         step();
      end

      idle(4);
      stale = 0;
      foreach (exp_q[i]) if (exp_q[i].cyc <= edge_cnt) stale++;
      chk("retire_missing", 64'(stale), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
